lut_eval_seq: RTL and testbench

Programmable, registered truth-table evaluator: an N_IN-input single-output boolean function held in a 2^N_IN-entry table, evaluated one input vector per cycle with a valid-qualified, one-cycle-latency registered output. The table is reloaded at run time through a bit-serial configuration port into a shadow register, then committed atomically. Evaluation continues uninterrupted during a reload. The block sits in the combinational-logic lab datapath wherever a fixed 3-variable function was previously hard-coded. Its reset table reproduces that function, y = D·(B + C̄): minterms 1, 5 and 7.

---
 rtl/lut_eval_seq.sv | 128 ++++++++++++
 tb/tb_lut_eval_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_eval_seq.sv
// lut_eval_seq: programmable registered truth-table evaluator.
//
// Holds an N_IN-input, single-output boolean function as a 2^N_IN-entry table and
// evaluates one input vector per cycle. The result appears one cycle later, qualified
// by a valid flag. A new table is shifted in one bit at a time into a shadow register.
// It is then committed to the active table in a single edge, so evaluation never sees
// a half-loaded table.
//
// Ports:
//   i_clk        clock; all state changes on the rising edge
//   i_rst        synchronous active-high reset
//   i_in_valid   i_in_data is presented for evaluation this cycle
//   i_in_data    input vector; bit index k of the table is the result for vector k
//   o_out_valid  o_y holds the result of the vector accepted on the previous cycle
//   o_y          registered function value
//   i_cfg_start  begin or restart a table load
//   i_cfg_valid  i_cfg_bit is valid this cycle
//   i_cfg_bit    serial table bit; the first bit received is entry 0
//   o_cfg_busy   a load is in progress
//   o_cfg_done   one-cycle pulse on the cycle after the new table is committed
module lut_eval_seq #(
  parameter int unsigned             N_IN          = 3,
  parameter logic [(2**N_IN)-1:0]    DEFAULT_TABLE = 8'hA2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_in_valid,
  input  logic [N_IN-1:0] i_in_data,
  output logic            o_out_valid,
  output logic            o_y,
  input  logic            i_cfg_start,
  input  logic            i_cfg_valid,
  input  logic            i_cfg_bit,
  output logic            o_cfg_busy,
  output logic            o_cfg_done
);

  localparam int unsigned     Depth  = 2 ** N_IN;
  localparam logic [N_IN-1:0] CntMax = '1;
  localparam logic [N_IN-1:0] CntOne = 1;

  typedef enum logic {StIdle, StLoad} state_t;

  state_t            r_state;
  logic [N_IN-1:0]   r_cnt;
  logic [Depth-1:0]  r_shadow;
  logic [Depth-1:0]  r_table;
  logic              r_busy;
  logic              r_done;
  logic              r_y;
  logic              r_out_valid;

  // Shadow with the bit arriving this cycle already merged in. The commit
  // uses it so the final bit is included on the same edge.
  logic [Depth-1:0]  w_shadow_merged;

  always_comb begin
    w_shadow_merged        = r_shadow;
    w_shadow_merged[r_cnt] = i_cfg_bit;
  end

  // Configuration state machine: shadow fill, commit, and status flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_table  <= DEFAULT_TABLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // A cfg_valid in the same cycle as cfg_start is ignored.
          if (i_cfg_start) begin
            r_state <= StLoad;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        StLoad: begin
          if (i_cfg_start) begin
            // Restart: drop the partial table; start has priority over a bit.
            r_cnt    <= '0;
            r_shadow <= '0;
          end else if (i_cfg_valid) begin
            r_shadow <= w_shadow_merged;
            if (r_cnt == CntMax) begin
              r_table <= w_shadow_merged;
              r_cnt   <= '0;
              r_state <= StIdle;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CntOne;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Evaluation path. It reads the active table as it stands before any commit on
  // the same edge, so a vector accepted alongside the final config bit sees
  // the old table.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_y         <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= i_in_valid;
      if (i_in_valid) begin
        r_y <= r_table[i_in_data];
      end
    end
  end

  assign o_y         = r_y;
  assign o_out_valid = r_out_valid;
  assign o_cfg_busy  = r_busy;
  assign o_cfg_done  = r_done;

endmodule

// File: tb/tb_lut_eval_seq.sv
// Directed bench for lut_eval_seq. It runs a default 3-input instance and a 2-input
// AND instance on a shared clock and reset.
module tb_lut_eval_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid = 1'b0;
  logic [2:0] in_data = '0;
  logic       cfg_start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_bit = 1'b0;
  logic       out_valid, y, cfg_busy, cfg_done;

  logic       in_valid2 = 1'b0;
  logic [1:0] in_data2 = '0;
  logic       cfg_start2 = 1'b0;
  logic       cfg_valid2 = 1'b0;
  logic       cfg_bit2 = 1'b0;
  logic       out_valid2, y2, cfg_busy2, cfg_done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lut_eval_seq u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .o_out_valid (out_valid),
    .o_y         (y),
    .i_cfg_start (cfg_start),
    .i_cfg_valid (cfg_valid),
    .i_cfg_bit   (cfg_bit),
    .o_cfg_busy  (cfg_busy),
    .o_cfg_done  (cfg_done)
  );

  lut_eval_seq #(
    .N_IN          (2),
    .DEFAULT_TABLE (4'h8)
  ) u_dut2 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid2),
    .i_in_data   (in_data2),
    .o_out_valid (out_valid2),
    .o_y         (y2),
    .i_cfg_start (cfg_start2),
    .i_cfg_valid (cfg_valid2),
    .i_cfg_bit   (cfg_bit2),
    .o_cfg_busy  (cfg_busy2),
    .o_cfg_done  (cfg_done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sweep every input vector and compare against the expected table.
  task automatic sweep(input logic [7:0] tab, input string tag);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 3'(i);
      tick();
      check($sformatf("%s y[%0d]", tag, i), {31'b0, y}, {31'b0, tab[i]});
      check($sformatf("%s valid[%0d]", tag, i), {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check({tag, " valid low"}, {31'b0, out_valid}, 32'd0);
    check({tag, " y hold"}, {31'b0, y}, {31'b0, tab[7]});
  endtask

  // Send 8 bits (optionally with gaps). The probe vector rides with the final
  // bit and is repeated once afterwards to check the commit boundary.
  task automatic send_bits(input logic [7:0] tab, input logic [7:0] old_tab,
                           input logic [2:0] probe, input bit gaps, input string tag);
    for (int k = 0; k < 8; k++) begin
      if (gaps && (k % 3 == 1)) begin
        cfg_valid = 1'b0;
        tick();
        check($sformatf("%s gap busy %0d", tag, k), {31'b0, cfg_busy}, 32'd1);
        check($sformatf("%s gap done %0d", tag, k), {31'b0, cfg_done}, 32'd0);
      end
      cfg_valid = 1'b1;
      cfg_bit   = tab[k];
      if (k == 7) begin
        in_valid = 1'b1;
        in_data  = probe;
      end
      tick();
      if (k < 7) begin
        check($sformatf("%s busy %0d", tag, k), {31'b0, cfg_busy}, 32'd1);
        check($sformatf("%s done %0d", tag, k), {31'b0, cfg_done}, 32'd0);
      end else begin
        check({tag, " done pulse"}, {31'b0, cfg_done}, 32'd1);
        check({tag, " busy fall"}, {31'b0, cfg_busy}, 32'd0);
        check({tag, " old-table y"}, {31'b0, y}, {31'b0, old_tab[probe]});
      end
    end
    cfg_valid = 1'b0;
    tick();
    check({tag, " new-table y"}, {31'b0, y}, {31'b0, tab[probe]});
    check({tag, " done one cycle"}, {31'b0, cfg_done}, 32'd0);
    in_valid = 1'b0;
    tick();
  endtask

  task automatic load(input logic [7:0] tab, input logic [7:0] old_tab,
                      input logic [2:0] probe, input string tag);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check({tag, " busy rise"}, {31'b0, cfg_busy}, 32'd1);
    send_bits(tab, old_tab, probe, 1'b0, tag);
  endtask

  initial begin
    logic [7:0] t_xor3;
    logic [7:0] t_dflt;
    logic [7:0] t_3c;
    logic [3:0] t_and2;
    logic [3:0] t_xor2;
    t_xor3 = 8'h96;
    t_dflt = 8'hA2;
    t_3c   = 8'h3C;
    t_and2 = 4'h8;
    t_xor2 = 4'h6;

    // Reset with in_valid high must produce no output.
    in_valid = 1'b1;
    in_data  = 3'd1;
    tick();
    tick();
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst y", {31'b0, y}, 32'd0);
    check("rst busy", {31'b0, cfg_busy}, 32'd0);
    check("rst done", {31'b0, cfg_done}, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();

    sweep(t_dflt, "dflt");

    // XOR3 reload; boundary probe 3 (0 in both tables).
    load(t_xor3, t_dflt, 3'd3, "xor3");
    sweep(t_xor3, "xor3");

    // Back to the default, then boundary probe 1 (1 in both tables).
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load(t_xor3, t_dflt, 3'd1, "xor3b");
    // Probe 5 differs between tables: 0 in 8'h96, 1 in 8'hA2.
    load(t_dflt, t_xor3, 3'd5, "back");

    // Restarted load: 4 bits with a gap, then restart with a simultaneous bit.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cfg_valid = (k != 2);
      cfg_bit   = 1'b1;
      tick();
      check($sformatf("part busy %0d", k), {31'b0, cfg_busy}, 32'd1);
      check($sformatf("part done %0d", k), {31'b0, cfg_done}, 32'd0);
    end
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("restart busy", {31'b0, cfg_busy}, 32'd1);
    check("restart done", {31'b0, cfg_done}, 32'd0);
    send_bits(t_3c, t_dflt, 3'd2, 1'b1, "gapped");
    sweep(t_3c, "t3c");

    // Reset mid-load after 5 bits.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cfg_valid = 1'b1;
      cfg_bit   = t_xor3[k];
      tick();
    end
    cfg_valid = 1'b1;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    cfg_valid = 1'b0;
    check("midrst busy", {31'b0, cfg_busy}, 32'd0);
    check("midrst done", {31'b0, cfg_done}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b0;
      tick();
      check($sformatf("midrst no done %0d", k), {31'b0, cfg_done}, 32'd0);
      check($sformatf("midrst idle %0d", k), {31'b0, cfg_busy}, 32'd0);
    end
    cfg_valid = 1'b0;
    sweep(t_dflt, "midrst");

    // Two-input instance: default AND, then load XOR2.
    for (int i = 0; i < 4; i++) begin
      in_valid2 = 1'b1;
      in_data2  = 2'(i);
      tick();
      check($sformatf("and2 y[%0d]", i), {31'b0, y2}, {31'b0, t_and2[i]});
      check($sformatf("and2 valid[%0d]", i), {31'b0, out_valid2}, 32'd1);
    end
    in_valid2  = 1'b0;
    cfg_start2 = 1'b1;
    tick();
    cfg_start2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cfg_valid2 = 1'b1;
      cfg_bit2   = t_xor2[k];
      tick();
      check($sformatf("n2 done %0d", k), {31'b0, cfg_done2}, (k == 3) ? 32'd1 : 32'd0);
      check($sformatf("n2 busy %0d", k), {31'b0, cfg_busy2}, (k == 3) ? 32'd0 : 32'd1);
    end
    cfg_valid2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid2 = 1'b1;
      in_data2  = 2'(i);
      tick();
      check($sformatf("xor2 y[%0d]", i), {31'b0, y2}, {31'b0, t_xor2[i]});
    end
    in_valid2 = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
